// File: rtl/h264_loader_pkg.sv
// Shared types and geometry constants for the H264 macroblock loader.
package h264_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    LOAD,
    WAIT_DROP,
    DRAIN
  } state_t;

  localparam int unsigned MB_WORDS  = 64;
  localparam int unsigned ROW_WORDS = 4;
  localparam int unsigned MB_DIM    = 16;

  localparam int unsigned CNT_W    = 7;
  localparam int unsigned COL_W    = $clog2(ROW_WORDS);
  localparam int unsigned ROW_W    = $clog2(MB_DIM);
  localparam int unsigned MB_IDX_W = 6;
  localparam int unsigned OUTST_W  = 4;

endpackage

// File: rtl/h264_mb_loader_if.sv
// In-order read bus between the loader (master) and system memory (slave).
interface h264_mb_loader_if #(
  parameter int unsigned AW = 32
) ();

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/h264_mb_addr_gen.sv
// Word address of (row, col) inside the current macroblock; the row base is
// accumulated so only an add of FRAME_W is needed when the row steps.
module h264_mb_addr_gen
  import h264_loader_pkg::*;
#(
  parameter int unsigned FRAME_W = 640,
  parameter int unsigned AW      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [AW-1:0]       base,
  input  logic [MB_IDX_W-1:0] mb_x,
  input  logic [MB_IDX_W-1:0] mb_y,
  input  logic [ROW_W-1:0]    row,
  input  logic [COL_W-1:0]    col,
  output logic [AW-1:0]       mem_addr
);

  localparam logic [AW-1:0] ROW_STRIDE    = AW'(FRAME_W);
  localparam logic [AW-1:0] MB_ROW_STRIDE = AW'(FRAME_W * MB_DIM);

  logic [AW-1:0]    acc;
  logic [AW-1:0]    row_base;
  logic [ROW_W-1:0] acc_row;

  // init recomputes the MB origin; otherwise row only ever steps by one
  always_comb begin
    row_base = acc;
    if (init) begin
      row_base = base + AW'(mb_y) * MB_ROW_STRIDE + AW'(mb_x) * AW'(MB_DIM);
    end else if (row != acc_row) begin
      row_base = acc + ROW_STRIDE;
    end
  end

  assign mem_addr = row_base + (AW'(col) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_row <= '0;
    end else begin
      acc     <= row_base;
      acc_row <= init ? '0 : row;
    end
  end

endmodule

// File: rtl/h264_mb_loader.sv
// Fetches 16x16 luma macroblocks in raster order from memory and streams
// them to the encoder core, one macroblock per fetch_req.
module h264_mb_loader
  import h264_loader_pkg::*;
#(
  parameter int unsigned FRAME_W   = 640,
  parameter int unsigned FRAME_H   = 480,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned AW        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  h264_reset,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic                  fetch_req,
  output logic                  data_valid,
  output logic [31:0]           data_word,
  h264_mb_loader_if.master      mem,
  output logic [MB_IDX_W-1:0]   mb_x_o,
  output logic [MB_IDX_W-1:0]   mb_y_o,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned       MB_COLS   = FRAME_W / MB_DIM;
  localparam int unsigned       MB_ROWS   = FRAME_H / MB_DIM;
  localparam logic [MB_IDX_W-1:0] LAST_X  = MB_IDX_W'(MB_COLS - 1);
  localparam logic [MB_IDX_W-1:0] LAST_Y  = MB_IDX_W'(MB_ROWS - 1);
  localparam logic [OUTST_W-1:0]  OUTST_MAX = OUTST_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0]    WORDS     = CNT_W'(MB_WORDS);
  localparam logic [CNT_W-1:0]    LAST_WORD = CNT_W'(MB_WORDS - 1);

  state_t               state;
  logic [AW-1:0]        base;
  logic [MB_IDX_W-1:0]  mb_x;
  logic [MB_IDX_W-1:0]  mb_y;
  logic [CNT_W-1:0]     issued;
  logic [CNT_W-1:0]     rcvd;
  logic [OUTST_W-1:0]   outst;

  logic                 gnt_fire;
  logic                 rsp;
  logic                 addr_init;
  logic [CNT_W-1:0]     issued_n;
  logic [OUTST_W-1:0]   outst_n;
  logic [AW-1:0]        addr_c;

  assign gnt_fire  = mem.mem_req & mem.mem_gnt;
  assign rsp       = mem.mem_rvalid & (outst != '0);
  assign issued_n  = issued + CNT_W'(gnt_fire);
  assign addr_init = (state != LOAD);
  assign mb_x_o    = mb_x;
  assign mb_y_o    = mb_y;

  // reads in flight after this cycle's grant/response
  always_comb begin
    outst_n = outst;
    if (gnt_fire && !rsp) begin
      outst_n = outst + OUTST_W'(1);
    end else if (!gnt_fire && rsp) begin
      outst_n = outst - OUTST_W'(1);
    end
  end

  h264_mb_addr_gen #(
    .FRAME_W (FRAME_W),
    .AW      (AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (addr_init),
    .base     (base),
    .mb_x     (mb_x),
    .mb_y     (mb_y),
    .row      (issued_n[COL_W +: ROW_W]),
    .col      (issued_n[COL_W-1:0]),
    .mem_addr (addr_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      mb_x         <= '0;
      mb_y         <= '0;
      issued       <= '0;
      rcvd         <= '0;
      outst        <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      data_valid   <= 1'b0;
      data_word    <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      outst      <= outst_n;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      if (h264_reset) begin
        // in-flight reads must still be absorbed before a new frame can start
        mb_x        <= '0;
        mb_y        <= '0;
        issued      <= '0;
        rcvd        <= '0;
        mem.mem_req <= 1'b0;
        if (outst_n != '0) begin
          state <= DRAIN;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              base  <= base_addr;
              mb_x  <= '0;
              mb_y  <= '0;
              busy  <= 1'b1;
              state <= WAIT_REQ;
            end
          end
          WAIT_REQ: begin
            if (fetch_req) begin
              issued       <= '0;
              rcvd         <= '0;
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= addr_c;
              state        <= LOAD;
            end
          end
          LOAD: begin
            // an ungranted request holds: issued and the row base stay put
            issued       <= issued_n;
            mem.mem_req  <= (issued_n < WORDS) && (outst_n < OUTST_MAX);
            mem.mem_addr <= addr_c;
            if (rsp) begin
              data_valid <= 1'b1;
              data_word  <= mem.mem_rdata;
              rcvd       <= rcvd + CNT_W'(1);
              if (rcvd == LAST_WORD) begin
                state <= WAIT_DROP;
              end
            end
          end
          WAIT_DROP: begin
            if (!fetch_req) begin
              if (mb_x == LAST_X && mb_y == LAST_Y) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                if (mb_x == LAST_X) begin
                  mb_x <= '0;
                  mb_y <= mb_y + MB_IDX_W'(1);
                end else begin
                  mb_x <= mb_x + MB_IDX_W'(1);
                end
                state <= WAIT_REQ;
              end
            end
          end
          DRAIN: begin
            if (outst_n == '0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_h264_mb_loader.sv
// Directed bench for h264_mb_loader on a 32x32 frame with a queued memory model.
module tb_h264_mb_loader;

  logic        clk;
  logic        rst;
  logic        h264_reset;
  logic        start;
  logic [31:0] base_addr;
  logic        fetch_req;
  logic        data_valid;
  logic [31:0] data_word;
  logic [5:0]  mb_x_o;
  logic [5:0]  mb_y_o;
  logic        busy;
  logic        frame_done;

  h264_mb_loader_if #(.AW(32)) mem_if ();

  h264_mb_loader #(
    .FRAME_W   (32),
    .FRAME_H   (32),
    .MAX_OUTST (4),
    .AW        (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .h264_reset (h264_reset),
    .start      (start),
    .base_addr  (base_addr),
    .fetch_req  (fetch_req),
    .data_valid (data_valid),
    .data_word  (data_word),
    .mem        (mem_if),
    .mb_x_o     (mb_x_o),
    .mb_y_o     (mb_y_o),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] got[$];
  logic [31:0] gaddr[$];
  logic [31:0] pa[$];
  int          pd[$];
  int          n_gnt = 0;
  int          n_rsp = 0;
  int          max_o = 0;
  int          hold_bad = 0;
  int          fd_cnt = 0;
  int          cyc = 0;
  int          gnt_pct = 100;
  int          lat = 1;
  logic        prev_req = 1'b0;
  logic        prev_gnt = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // memory model and output monitor, all on the falling edge
  initial begin
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (data_valid) got.push_back(data_word);
      if (frame_done) fd_cnt++;
      if (prev_req && !prev_gnt && (!mem_if.mem_req || mem_if.mem_addr != prev_addr)) hold_bad++;
      cyc++;
      mem_if.mem_rvalid = 1'b0;
      if (pa.size() > 0 && pd[0] <= cyc) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = dat(pa[0]);
        void'(pa.pop_front());
        void'(pd.pop_front());
        n_rsp++;
      end
      mem_if.mem_gnt = ($urandom_range(99) < gnt_pct);
      if (mem_if.mem_req && mem_if.mem_gnt) begin
        pa.push_back(mem_if.mem_addr);
        pd.push_back(cyc + lat);
        gaddr.push_back(mem_if.mem_addr);
        n_gnt++;
      end
      if (n_gnt - n_rsp > max_o) max_o = n_gnt - n_rsp;
      prev_req  = mem_if.mem_req;
      prev_gnt  = mem_if.mem_gnt;
      prev_addr = mem_if.mem_addr;
    end
  end

  // Load one MB and compare every granted address and returned word.
  task automatic run_mb(input int mbx, input int mby, input logic [31:0] base,
                        input bit disturb, input logic [31:0] first_exp);
    int n;
    int bad;
    bit mid_done;
    bit dist_done;
    logic [31:0] a;
    got.delete();
    gaddr.delete();
    fetch_req = 1'b1;
    n = 0;
    mid_done = 1'b0;
    dist_done = 1'b0;
    while (got.size() < 64 && n < 4000) begin
      tick();
      n++;
      start = 1'b0;
      base_addr = 32'h1000;
      if (!mid_done && got.size() == 32) begin
        mid_done = 1'b1;
        chk("mb_x_mid", 64'(mb_x_o), 64'(mbx));
        chk("mb_y_mid", 64'(mb_y_o), 64'(mby));
      end
      if (disturb && !dist_done && got.size() >= 20) begin
        dist_done = 1'b1;
        start = 1'b1;
        base_addr = 32'h8000;
        fetch_req = 1'b0;
      end
    end
    chk("mb_timeout", 64'(n < 4000), 64'd1);
    chk("first_addr", 64'(gaddr.size() > 0 ? gaddr[0] : 32'hFFFF_FFFF), 64'(first_exp));
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      a = base + 32'((mby * 16 + i / 4) * 32 + mbx * 16 + (i % 4) * 4);
      if (gaddr.size() <= i || gaddr[i] !== a) bad++;
      if (got.size() <= i || got[i] !== dat(a)) bad++;
    end
    chk("mb_words", 64'(bad), 64'd0);
  endtask

  initial begin
    int n;
    int g0;
    int r0;
    int dv0;
    rst = 1'b1;
    h264_reset = 1'b0;
    start = 1'b0;
    base_addr = 32'h1000;
    fetch_req = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dv", 64'(data_valid), 64'd0);
    chk("rst_req", 64'(mem_if.mem_req), 64'd0);
    chk("rst_addr", 64'(mem_if.mem_addr), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    chk("rst_mbx", 64'(mb_x_o), 64'd0);
    chk("rst_mby", 64'(mb_y_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // zero-wait memory, MB(0,0), then hold fetch_req high after the last word
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    run_mb(0, 0, 32'h1000, 1'b0, 32'h1000);
    chk("fifth_addr", 64'(gaddr.size() > 4 ? gaddr[4] : 32'hFFFF_FFFF), 64'h1020);
    repeat (5) tick();
    chk("hold_no_reads", 64'(gaddr.size()), 64'd64);
    chk("hold_dv_count", 64'(got.size()), 64'd64);
    chk("hold_mbx", 64'(mb_x_o), 64'd0);
    fetch_req = 1'b0;
    tick();
    chk("adv_mbx", 64'(mb_x_o), 64'd1);
    chk("adv_mby", 64'(mb_y_o), 64'd0);

    // rest of the frame
    run_mb(1, 0, 32'h1000, 1'b0, 32'h1010);
    fetch_req = 1'b0;
    tick();
    run_mb(0, 1, 32'h1000, 1'b0, 32'h1200);
    fetch_req = 1'b0;
    tick();
    run_mb(1, 1, 32'h1000, 1'b0, 32'h1210);
    chk("last_addr", 64'(gaddr.size() == 64 ? gaddr[63] : 32'hFFFF_FFFF), 64'h13FC);
    fetch_req = 1'b0;
    repeat (3) tick();
    chk("frame_done_cnt", 64'(fd_cnt), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);

    // random grants, 5-cycle read latency
    gnt_pct = 30;
    lat = 5;
    max_o = 0;
    hold_bad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_mb(0, 0, 32'h1000, 1'b0, 32'h1000);
    chk("max_outst", 64'(max_o <= 4), 64'd1);
    chk("addr_hold", 64'(hold_bad), 64'd0);
    gnt_pct = 100;
    fetch_req = 1'b0;
    tick();

    // soft reset with three reads in flight, MB(1,0) mid-load
    lat = 3;
    got.delete();
    g0 = n_gnt;
    fetch_req = 1'b1;
    n = 0;
    while (n_gnt - g0 < 10 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_grants_timeout", 64'(n < 200), 64'd1);
    h264_reset = 1'b1;
    tick();
    h264_reset = 1'b0;
    fetch_req = 1'b0;
    chk("drain_req", 64'(mem_if.mem_req), 64'd0);
    chk("drain_inflight", 64'(n_gnt - n_rsp), 64'd3);
    chk("drain_busy", 64'(busy), 64'd1);
    r0 = n_rsp;
    dv0 = got.size();
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    chk("drain_rsp", 64'(n_rsp - r0), 64'd3);
    chk("drain_swallow", 64'(got.size()), 64'(dv0));
    chk("drain_mbx", 64'(mb_x_o), 64'd0);
    chk("drain_mby", 64'(mb_y_o), 64'd0);

    // restart; start while busy and fetch_req drop mid-load are ignored
    lat = 1;
    start = 1'b1;
    base_addr = 32'h1000;
    tick();
    start = 1'b0;
    chk("restart_busy", 64'(busy), 64'd1);
    run_mb(0, 0, 32'h1000, 1'b1, 32'h1000);
    repeat (3) tick();
    chk("dist_dv_count", 64'(got.size()), 64'd64);
    chk("dist_reads", 64'(gaddr.size()), 64'd64);
    chk("dist_adv_mbx", 64'(mb_x_o), 64'd1);
    chk("dist_busy", 64'(busy), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
